// File: rtl/fifo_rd_stream.sv
// Read-side output stage of the async FIFO: turns the pop/registered-read interface into a
// valid/ready stream through a 2-entry holding buffer, and counts delivered words.
module fifo_rd_stream #(
  parameter int unsigned DATAW = 8,
  parameter int unsigned CNTW  = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             empty_i,
  input  logic [DATAW-1:0] rdata_i,
  output logic             rinc_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [DATAW-1:0] m_data_o,
  output logic [CNTW-1:0]  out_cnt_o
);

  logic [DATAW-1:0] slot0_q, slot0_d;
  logic [DATAW-1:0] slot1_q, slot1_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             inflight_q;
  logic [CNTW-1:0]  out_cnt_q;
  logic             pop;
  logic [2:0]       occ;

  assign m_valid_o = (cnt_q != 2'd0);
  assign m_data_o  = slot0_q;
  assign out_cnt_o = out_cnt_q;
  assign pop       = m_valid_o & m_ready_i;

  // Slots already spoken for once this cycle's transfer leaves; keeping it below 2 means a
  // newly requested word always has a free slot when it arrives.
  assign occ    = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rinc_o = ~rrst & ~empty_i & (occ < 3'd2);

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    cnt_d   = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    if (pop && (cnt_q == 2'd2)) begin
      slot0_d = slot1_q;
    end
    if (inflight_q) begin
      case (cnt_q)
        2'd0: slot0_d = rdata_i;
        2'd1: begin
          if (pop) begin
            slot0_d = rdata_i;
          end else begin
            slot1_d = rdata_i;
          end
        end
        default: slot1_d = rdata_i;
      endcase
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      slot0_q    <= '0;
      slot1_q    <= '0;
      cnt_q      <= 2'd0;
      inflight_q <= 1'b0;
      out_cnt_q  <= '0;
    end else begin
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
      cnt_q      <= cnt_d;
      inflight_q <= rinc_o & ~empty_i;
      if (pop) begin
        out_cnt_q <= out_cnt_q + 1'b1;
      end
    end
  end

endmodule
